// File: rtl/bus_pkg.sv
// D-bus transfer encodings shared by every master and slave on dbus_interconnect.
package bus_pkg;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } bus_ttype_t;

   typedef enum logic [1:0] {
      BYTE     = 2'd0,
      HALFWORD = 2'd1,
      WORD     = 2'd2
   } bus_tsize_t;

endpackage

// File: rtl/dbg_pkg.sv
// Debug module definitions: DMI register map and system bus access fields.
package dbg_pkg;

   localparam logic [6:0] SBCS       = 7'h38;
   localparam logic [6:0] SBADDRESS0 = 7'h39;
   localparam logic [6:0] SBDATA0    = 7'h3C;

   typedef struct packed {
      logic [2:0] sbversion;
      logic [5:0] rsvd_28_23;
      logic       sbbusyerror;
      logic       sbbusy;
      logic       sbreadonaddr;
      logic [2:0] sbaccess;
      logic       sbautoincrement;
      logic       sbreadondata;
      logic [2:0] sberror;
      logic [6:0] sbasize;
      logic [1:0] rsvd_4_3;
      logic [2:0] sbaccess_sup;
   } sbcs_t;

   typedef enum logic [2:0] {
      NONE    = 3'd0,
      TIMEOUT = 3'd1,
      ALIGN   = 3'd3,
      SIZE    = 3'd4,
      OTHER   = 3'd7
   } sb_error_t;

endpackage

// File: rtl/dm_sba.sv
// System bus access engine: turns sbcs/sbaddress0/sbdata0 DMI traffic into
// single D-bus transfers.
module dm_sba #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        reg_wr,
   input  logic        reg_rd,
   input  logic [6:0]  reg_addr,
   input  logic [31:0] reg_wdata,
   output logic [31:0] sbcs_o,
   output logic [31:0] sbaddress0_o,
   output logic [31:0] sbdata0_o,
   output logic        bus_bstart,
   output logic [31:0] bus_addr,
   output logic        bus_ttype,
   output logic [1:0]  bus_tsize,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_bdone,
   input  logic        bus_berr
);
   import dbg_pkg::*;
   import bus_pkg::*;

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t           state, state_nxt;
   logic             readonaddr, autoinc, readondata, busyerror;
   logic [2:0]       access, sberror, sberror_nxt;
   logic [31:0]      sbaddress0, sbdata0, rdata_q, trig_addr, inc;
   logic             berr_q, busy;
   logic [CNT_W-1:0] cnt;
   logic             wr_sbcs, wr_addr, wr_data, rd_data, sb_access;
   logic             trigger, gated, size_bad, align_bad, start, start_err, timeout;
   sbcs_t            sbcs;

   function automatic logic [31:0] zext(input logic [31:0] d, input logic [1:0] sz);
      case (sz)
         BYTE:     return {24'h0, d[7:0]};
         HALFWORD: return {16'h0, d[15:0]};
         default:  return d;
      endcase
   endfunction

   always_comb begin
      wr_sbcs   = reg_wr && (reg_addr == SBCS);
      wr_addr   = reg_wr && (reg_addr == SBADDRESS0);
      wr_data   = reg_wr && (reg_addr == SBDATA0);
      rd_data   = reg_rd && (reg_addr == SBDATA0);
      sb_access = wr_addr || wr_data || rd_data;
      trigger   = !busy && ((wr_addr && readonaddr) || wr_data || (rd_data && readondata));
      // a write to sbaddress0 starts its read at the address being written
      trig_addr = wr_addr ? reg_wdata : sbaddress0;
      gated     = (sberror != NONE) || busyerror;
      size_bad  = access > 3'(WORD);
      align_bad = ((access == 3'(HALFWORD)) && trig_addr[0]) ||
                  ((access == 3'(WORD)) && (trig_addr[1:0] != 2'b00));
      start     = trigger && !gated && !size_bad && !align_bad;
      start_err = trigger && !gated && (size_bad || align_bad);
      timeout   = (state == WAIT) && !bus_bdone && (cnt == CNT_MAX);
      inc       = 32'd1 << bus_tsize;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = REQ;
         REQ:     state_nxt = WAIT;
         WAIT:    if (bus_bdone) state_nxt = DONE;
                  else if (timeout) state_nxt = IDLE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      bus_bstart = (state == REQ);
   end

   // hardware-detected errors win over a same-cycle W1C clear
   always_comb begin
      sberror_nxt = sberror;
      if (wr_sbcs) sberror_nxt = sberror & ~reg_wdata[14:12];
      if (start_err) sberror_nxt = size_bad ? SIZE : ALIGN;
      if (timeout) sberror_nxt = TIMEOUT;
      if ((state == DONE) && berr_q) sberror_nxt = OTHER;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         readonaddr <= 1'b0;
         access     <= '0;
         autoinc    <= 1'b0;
         readondata <= 1'b0;
         busyerror  <= 1'b0;
         sberror    <= '0;
         sbaddress0 <= '0;
         sbdata0    <= '0;
         rdata_q    <= '0;
         berr_q     <= 1'b0;
         cnt        <= '0;
         bus_addr   <= '0;
         bus_ttype  <= 1'b0;
         bus_tsize  <= '0;
         bus_wdata  <= '0;
      end else begin
         sberror <= sberror_nxt;
         if (wr_sbcs) begin
            readonaddr <= reg_wdata[20];
            access     <= reg_wdata[19:17];
            autoinc    <= reg_wdata[16];
            readondata <= reg_wdata[15];
         end
         if (busy && sb_access) busyerror <= 1'b1;
         else if (wr_sbcs && reg_wdata[22]) busyerror <= 1'b0;

         if (!busy && wr_addr) sbaddress0 <= reg_wdata;
         else if ((state == DONE) && !berr_q && autoinc) sbaddress0 <= sbaddress0 + inc;

         if (!busy && wr_data) sbdata0 <= reg_wdata;
         else if ((state == DONE) && (bus_ttype == READ)) sbdata0 <= zext(rdata_q, bus_tsize);

         if ((state == WAIT) && bus_bdone) begin
            rdata_q <= bus_rdata;
            berr_q  <= bus_berr;
         end

         if (start) begin
            bus_addr  <= trig_addr;
            bus_ttype <= wr_data ? WRITE : READ;
            bus_tsize <= access[1:0];
            bus_wdata <= wr_data ? reg_wdata : sbdata0;
            cnt       <= '0;
         end else if (busy && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      sbcs                 = '0;
      sbcs.sbversion       = 3'd1;
      sbcs.sbbusyerror     = busyerror;
      sbcs.sbbusy          = busy;
      sbcs.sbreadonaddr    = readonaddr;
      sbcs.sbaccess        = access;
      sbcs.sbautoincrement = autoinc;
      sbcs.sbreadondata    = readondata;
      sbcs.sberror         = sberror;
      sbcs.sbasize         = 7'd32;
      sbcs.sbaccess_sup    = 3'b111;
      sbcs_o               = sbcs;
   end

   assign sbaddress0_o = sbaddress0;
   assign sbdata0_o    = sbdata0;

endmodule

// File: tb/tb_dm_sba.sv
// Bench for dm_sba: transaction-level model checked every cycle plus directed
// scenarios with hand-computed expectations.
module tb_dm_sba;
   localparam int unsigned TMO = 8;
   localparam logic [6:0] A_SBCS = 7'h38;
   localparam logic [6:0] A_ADDR = 7'h39;
   localparam logic [6:0] A_DATA = 7'h3C;
   localparam logic [31:0] SBCS_RST = 32'h2000_0407;

   logic        clk = 1'b0, rst_n = 1'b0, reg_wr = 1'b0, reg_rd = 1'b0;
   logic [6:0]  reg_addr = '0;
   logic [31:0] reg_wdata = '0, bus_rdata = '0;
   logic        bus_bdone = 1'b0, bus_berr = 1'b0;
   logic [31:0] sbcs_o, sbaddress0_o, sbdata0_o, bus_addr, bus_wdata;
   logic        bus_bstart, bus_ttype;
   logic [1:0]  bus_tsize;

   int errors = 0;
   int checks = 0;

   dm_sba #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .reg_wr(reg_wr), .reg_rd(reg_rd),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .sbcs_o(sbcs_o), .sbaddress0_o(sbaddress0_o), .sbdata0_o(sbdata0_o),
      .bus_bstart(bus_bstart), .bus_addr(bus_addr), .bus_ttype(bus_ttype),
      .bus_tsize(bus_tsize), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_bdone(bus_bdone), .bus_berr(bus_berr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic        m_roa, m_ainc, m_rod, m_busyerr, m_busy, m_berr;
   logic [2:0]  m_acc, m_err;
   logic [31:0] m_addr, m_data, m_rdata;
   logic [31:0] mb_addr, mb_wdata;
   logic        mb_ttype;
   logic [1:0]  mb_tsize;
   int          cyc, t_start, done_at;

   typedef struct {
      logic [31:0] addr;
      logic        ttype;
      logic [1:0]  tsize;
      logic [31:0] wdata;
   } txn_t;
   txn_t txq[$];

   task automatic model_reset();
      m_roa = 0; m_ainc = 0; m_rod = 0; m_busyerr = 0; m_busy = 0; m_berr = 0;
      m_acc = 0; m_err = 0; m_addr = 0; m_data = 0; m_rdata = 0;
      mb_addr = 0; mb_wdata = 0; mb_ttype = 0; mb_tsize = 0;
      t_start = -1; done_at = -1;
   endtask

   function automatic logic [31:0] exp_sbcs();
      return (32'd1 << 29) | (32'(m_busyerr) << 22) | (32'(m_busy) << 21) |
             (32'(m_roa) << 20) | (32'(m_acc) << 17) | (32'(m_ainc) << 16) |
             (32'(m_rod) << 15) | (32'(m_err) << 12) | (32'd32 << 5) | 32'd7;
   endfunction

   function automatic logic [31:0] size_mask(input logic [31:0] d, input logic [1:0] sz);
      if (sz == 2'd0) return d & 32'h0000_00FF;
      if (sz == 2'd1) return d & 32'h0000_FFFF;
      return d;
   endfunction

   task automatic model_step();
      logic ws, wa, wd, rd, busy0, gated, ainc0, roa0, rod0, trig, has_err;
      logic [2:0] acc0, set_err;
      logic [31:0] ta, old_data;
      ws = reg_wr && (reg_addr == A_SBCS);
      wa = reg_wr && (reg_addr == A_ADDR);
      wd = reg_wr && (reg_addr == A_DATA);
      rd = reg_rd && (reg_addr == A_DATA);
      busy0 = m_busy; gated = (m_err != 0) || m_busyerr;
      ainc0 = m_ainc; roa0 = m_roa; rod0 = m_rod; acc0 = m_acc;
      has_err = 0; set_err = 0;
      if (busy0 && cyc != t_start) begin
         if (done_at == cyc) begin
            m_busy = 0;
            if (!mb_ttype) m_data = size_mask(m_rdata, mb_tsize);
            if (m_berr) begin has_err = 1; set_err = 7; end
            else if (ainc0) m_addr = m_addr + (32'd1 << mb_tsize);
         end else if (done_at < 0 && bus_bdone) begin
            done_at = cyc + 1; m_rdata = bus_rdata; m_berr = bus_berr;
         end else if (done_at < 0 && (cyc - t_start) == int'(TMO)) begin
            m_busy = 0; has_err = 1; set_err = 1;
         end
      end
      if (ws) begin
         m_roa = reg_wdata[20]; m_acc = reg_wdata[19:17];
         m_ainc = reg_wdata[16]; m_rod = reg_wdata[15];
         m_err = m_err & ~reg_wdata[14:12];
         if (reg_wdata[22]) m_busyerr = 0;
      end
      if (busy0 && (wa || wd || rd)) m_busyerr = 1;
      trig = !busy0 && ((wa && roa0) || wd || (rd && rod0));
      ta = wa ? reg_wdata : m_addr;
      old_data = m_data;
      if (!busy0 && wa) m_addr = reg_wdata;
      if (!busy0 && wd) m_data = reg_wdata;
      if (trig && !gated) begin
         if (acc0 > 3'd2) begin has_err = 1; set_err = 4; end
         else if ((acc0 == 3'd1 && ta % 2 != 0) || (acc0 == 3'd2 && ta % 4 != 0)) begin
            has_err = 1; set_err = 3;
         end else begin
            m_busy = 1; t_start = cyc + 1; done_at = -1;
            mb_addr = ta; mb_ttype = wd; mb_tsize = acc0[1:0];
            mb_wdata = wd ? reg_wdata : old_data;
         end
      end
      if (has_err) m_err = set_err;
   endtask

   initial begin
      model_reset();
      cyc = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) model_reset();
         chk("sbcs", sbcs_o, exp_sbcs());
         chk("sbaddress0", sbaddress0_o, m_addr);
         chk("sbdata0", sbdata0_o, m_data);
         chk("bstart", 32'(bus_bstart), 32'(m_busy && (cyc == t_start)));
         chk("bus_addr", bus_addr, mb_addr);
         chk("bus_ttype", 32'(bus_ttype), 32'(mb_ttype));
         chk("bus_tsize", 32'(bus_tsize), 32'(mb_tsize));
         if (mb_ttype) chk("bus_wdata", bus_wdata, mb_wdata);
         if (bus_bstart) txq.push_back('{bus_addr, bus_ttype, bus_tsize, bus_wdata});
         if (rst_n) model_step();
         cyc++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic dmi_wr(input logic [6:0] a, input logic [31:0] d);
      reg_wr = 1; reg_addr = a; reg_wdata = d;
      tick();
      reg_wr = 0;
   endtask

   task automatic dmi_rd(input logic [6:0] a);
      reg_rd = 1; reg_addr = a;
      tick();
      reg_rd = 0;
   endtask

   task automatic respond(input logic [31:0] rd, input logic berr);
      bus_bdone = 1; bus_rdata = rd; bus_berr = berr;
      tick();
      bus_bdone = 0; bus_rdata = '0; bus_berr = 0;
   endtask

   task automatic slave(input int delay, input logic [31:0] rd, input logic berr);
      int n = 0;
      while (!bus_bstart && n < 10) begin tick(); n++; end
      chk("bstart_seen", 32'(bus_bstart), 32'd1);
      if (bus_bstart) begin
         for (int i = 0; i < delay; i++) tick();
         respond(rd, berr);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_sbcs"}, sbcs_o, SBCS_RST);
      chk({tag, "_sbaddress0"}, sbaddress0_o, 32'h0);
      chk({tag, "_sbdata0"}, sbdata0_o, 32'h0);
      chk({tag, "_bstart"}, 32'(bus_bstart), 32'd0);
      chk({tag, "_bus_addr"}, bus_addr, 32'h0);
      chk({tag, "_bus_ttype"}, 32'(bus_ttype), 32'd0);
      chk({tag, "_bus_tsize"}, 32'(bus_tsize), 32'd0);
      chk({tag, "_bus_wdata"}, bus_wdata, 32'h0);
   endtask

   logic [31:0] wv[3] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D};

   initial begin
      int q0;
      repeat (3) tick();
      chk_reset_outputs("rst");
      rst_n = 1;
      tick();

      // Test 1: read on address write
      q0 = txq.size();
      dmi_wr(A_SBCS, 32'h0014_0000);
      dmi_wr(A_ADDR, 32'h3000_000C);
      slave(1, 32'h0000_00A5, 1'b0);
      tick();
      chk("t1_busy_low", 32'(sbcs_o[21]), 32'd0);
      chk("t1_sbdata0", sbdata0_o, 32'h0000_00A5);
      chk("t1_nxfer", txq.size(), q0 + 1);
      chk("t1_xaddr", txq[q0].addr, 32'h3000_000C);
      chk("t1_xttype", 32'(txq[q0].ttype), 32'd0);
      chk("t1_xtsize", 32'(txq[q0].tsize), 32'd2);

      // Test 2: auto-incrementing word writes
      dmi_wr(A_SBCS, 32'h0005_0000);
      dmi_wr(A_ADDR, 32'h1000_0000);
      q0 = txq.size();
      for (int i = 0; i < 3; i++) begin
         dmi_wr(A_DATA, wv[i]);
         slave(2, 32'h0, 1'b0);
         tick();
      end
      chk("t2_nxfer", txq.size(), q0 + 3);
      for (int i = 0; i < 3; i++) begin
         chk("t2_xaddr", txq[q0 + i].addr, 32'h1000_0000 + 32'(4 * i));
         chk("t2_xttype", 32'(txq[q0 + i].ttype), 32'd1);
         chk("t2_xwdata", txq[q0 + i].wdata, wv[i]);
      end
      chk("t2_addr_end", sbaddress0_o, 32'h1000_000C);

      // auto-increment wrap
      dmi_wr(A_ADDR, 32'hFFFF_FFFC);
      dmi_wr(A_DATA, 32'h0000_0011);
      slave(1, 32'h0, 1'b0);
      tick();
      chk("wrap_addr", sbaddress0_o, 32'h0000_0000);

      // byte read triggered by sbdata0 read, zero-extended
      dmi_wr(A_SBCS, 32'h0001_8000);
      dmi_wr(A_ADDR, 32'h2000_0003);
      q0 = txq.size();
      dmi_rd(A_DATA);
      slave(1, 32'hFFFF_FF5A, 1'b0);
      tick();
      chk("rod_data", sbdata0_o, 32'h0000_005A);
      chk("rod_addr", sbaddress0_o, 32'h2000_0004);
      chk("rod_xaddr", txq[q0].addr, 32'h2000_0003);
      chk("rod_xtsize", 32'(txq[q0].tsize), 32'd0);

      // Test 3: misaligned halfword, gating, W1C clear, bad size
      q0 = txq.size();
      dmi_wr(A_SBCS, 32'h0012_0000);
      dmi_wr(A_ADDR, 32'h1000_0001);
      tick();
      chk("t3_err_align", 32'(sbcs_o[14:12]), 32'd3);
      dmi_wr(A_ADDR, 32'h1000_0002);
      repeat (3) tick();
      chk("t3_addr_upd", sbaddress0_o, 32'h1000_0002);
      chk("t3_err_kept", 32'(sbcs_o[14:12]), 32'd3);
      chk("t3_no_xfer", txq.size(), q0);
      dmi_wr(A_SBCS, 32'h0012_3000);
      tick();
      chk("t3_err_clr", 32'(sbcs_o[14:12]), 32'd0);
      chk("t3_no_xfer2", txq.size(), q0);
      dmi_wr(A_SBCS, 32'h0016_0000);
      dmi_wr(A_ADDR, 32'h1000_0000);
      tick();
      chk("size_err", 32'(sbcs_o[14:12]), 32'd4);
      chk("size_no_xfer", txq.size(), q0);
      dmi_wr(A_SBCS, 32'h0000_7000);
      tick();

      // Test 4: timeout
      dmi_wr(A_SBCS, 32'h0014_0000);
      dmi_wr(A_ADDR, 32'h4000_0000);
      chk("t4_bstart", 32'(bus_bstart), 32'd1);
      repeat (8) tick();
      chk("t4_busy_before", 32'(sbcs_o[21]), 32'd1);
      tick();
      chk("t4_sbcs_timeout", sbcs_o, 32'h2014_1407);
      dmi_wr(A_SBCS, 32'h0000_1000);
      tick();

      // slave error on write: sberror=7, no increment
      dmi_wr(A_SBCS, 32'h0005_0000);
      dmi_wr(A_ADDR, 32'h5000_0000);
      dmi_wr(A_DATA, 32'h0BAD_0BAD);
      slave(1, 32'h0, 1'b1);
      tick();
      chk("berr_err", 32'(sbcs_o[14:12]), 32'd7);
      chk("berr_addr", sbaddress0_o, 32'h5000_0000);
      dmi_wr(A_SBCS, 32'h0000_7000);
      tick();

      // Test 5: sbdata0 write during WAIT
      dmi_wr(A_SBCS, 32'h0014_0000);
      q0 = txq.size();
      dmi_wr(A_ADDR, 32'h3000_0000);
      tick();
      dmi_wr(A_DATA, 32'h5555_5555);
      chk("t5_busyerr", 32'(sbcs_o[22]), 32'd1);
      chk("t5_data_kept", sbdata0_o, 32'h0BAD_0BAD);
      respond(32'h0000_0077, 1'b0);
      tick();
      chk("t5_read_data", sbdata0_o, 32'h0000_0077);
      chk("t5_one_xfer", txq.size(), q0 + 1);
      dmi_wr(A_ADDR, 32'h3000_0000);
      repeat (3) tick();
      chk("t5_gated", txq.size(), q0 + 1);
      dmi_wr(A_SBCS, 32'h0040_0000);
      tick();
      chk("t5_cleared", sbcs_o, SBCS_RST);

      // Test 6: reset during WAIT
      dmi_wr(A_SBCS, 32'h0014_0000);
      q0 = txq.size();
      dmi_wr(A_ADDR, 32'h3000_0004);
      tick();
      tick();
      rst_n = 0;
      #1;
      chk_reset_outputs("t6");
      tick();
      tick();
      rst_n = 1;
      repeat (20) tick();
      chk("t6_no_req", txq.size(), q0 + 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/dm_sba.md
# dm_sba

System Bus Access engine of the debug module. It owns the `sbcs`, `sbaddress0` and `sbdata0` DMI registers at 0x38, 0x39 and 0x3C, as defined by RISC-V Debug Spec 0.13. It turns DMI register traffic into single D-bus transfers on the debug module's `master_bus_if` port, so the debugger can read and write memory, GPIO and CLINT without halting the core. It sits downstream of the DMI decode in `dm` and upstream of `dbus_interconnect`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: bus cycles to wait for `bus_bdone` before raising sberror=1.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `reg_wr` in 1: single-cycle DMI write strobe, decoded by `dm`.
- `reg_rd` in 1: single-cycle DMI read strobe, decoded by `dm`.
- `reg_addr` in 7: DMI register address. Only 0x38, 0x39 and 0x3C are acted on.
- `reg_wdata` in 32: DMI write data.
- `sbcs_o` in-role output, out 32: live `sbcs` value.
- `sbaddress0_o` out 32: live `sbaddress0` value.
- `sbdata0_o` out 32: live `sbdata0` value.
- `bus_bstart` out 1: single-cycle transfer request.
- `bus_addr` out 32: transfer address.
- `bus_ttype` out 1: 0 = READ, 1 = WRITE.
- `bus_tsize` out 2: 0 = BYTE, 1 = HALFWORD, 2 = WORD.
- `bus_wdata` out 32: write data, right-justified.
- `bus_rdata` in 32: read data, right-justified, valid only when `bus_bdone`=1.
- `bus_bdone` in 1: transfer complete, single cycle.
- `bus_berr` in 1: slave error, sampled together with `bus_bdone`.

## Operation
`sbcs` field layout:
- [31:29] sbversion = 1.
- [22] sbbusyerror (W1C).
- [21] sbbusy (RO).
- [20] sbreadonaddr.
- [19:17] sbaccess.
- [16] sbautoincrement.
- [15] sbreadondata.
- [14:12] sberror (W1C, per bit).
- [11:5] sbasize = 32.
- [2:0] = 3'b111, meaning 8/16/32-bit accesses are supported.
- All other bits read as 0.

Reset state:
- All RW fields are 0.
- `sbaddress0` = 0, `sbdata0` = 0.
- `bus_bstart` = 0, `bus_addr` = 0, `bus_ttype` = 0, `bus_tsize` = 0, `bus_wdata` = 0.

Triggers:
- Write to `sbaddress0`: load the address; if sbreadonaddr=1, start a READ.
- Write to `sbdata0`: load the data, then start a WRITE.
- Read of `sbdata0` with sbreadondata=1: start a READ after the current value has been returned.

Start gating:
- No transfer starts while sberror≠0 or sbbusyerror=1. The register update still takes effect.
- Alignment is checked at start: addr[0] must be 0 for HALFWORD, addr[1:0] must be 0 for WORD. A misaligned start sets sberror=3 and no bus request is issued.
- sbaccess>2 sets sberror=4 and no bus request is issued.

FSM states:
- IDLE: a valid trigger moves to REQ.
- REQ: `bus_bstart`=1 for one cycle, then go to WAIT.
- WAIT:
  - `bus_bdone`=1 moves to DONE.
  - The timeout counter reaching `TIMEOUT_CYCLES` sets sberror=1 and moves to IDLE.
- DONE:
  - On READ, `sbdata0` is loaded with `bus_rdata`, zero-extended to the access size.
  - `bus_berr` sets sberror=7 and skips the address increment.
  - Otherwise, if sbautoincrement=1, `sbaddress0` += 1, 2 or 4 (mod 2^32).
  - Next state is IDLE.
- sbbusy = 1 in REQ, WAIT and DONE.

Boundary conditions:
- Any write to `sbaddress0` or `sbdata0`, or any read of `sbdata0`, while sbbusy=1 sets sbbusyerror and is otherwise ignored: no register change and no new transfer.
- A W1C write to `sbcs` takes effect the same cycle that the other RW fields are written.
- Auto-increment wraps from 0xFFFFFFFC to 0x00000000.
- An `rst_n` assertion during WAIT drops the transfer immediately. All state returns to its reset value and `bus_bstart` is never reasserted for the dropped transfer.

## Timing
- A register write in cycle N updates the register at the edge ending N; the register outputs show the new value in N+1.
- A trigger in cycle N gives `bus_bstart`=1 in N+1.
- `bus_addr`, `bus_ttype`, `bus_tsize` and `bus_wdata` are registered. They are valid from the `bus_bstart` cycle and held stable until the cycle after `bus_bdone`.
- `bus_bdone` in cycle M: `sbdata0` and `sbaddress0` are updated, and sbbusy falls, at the edge ending M+1.
- Minimum read latency from trigger to `sbdata0` valid is 4 cycles when the slave completes in 1 cycle.
- The timeout counter starts at 0 in the REQ cycle and saturates; sberror=1 is set on the cycle the count equals `TIMEOUT_CYCLES`.

## Structure
- Package `dbg_pkg`, shared with `dm`:
  - DMI addresses `SBCS`=0x38, `SBADDRESS0`=0x39, `SBDATA0`=0x3C.
  - A packed struct `sbcs_t` for the `sbcs` layout.
  - Enum `sb_error_t` with values NONE=0, TIMEOUT=1, ALIGN=3, SIZE=4, OTHER=7.
- Bus enums (READ/WRITE, BYTE/HALFWORD/WORD) come from the existing bus package.
- There are no sub-modules; the design is one FSM plus a datapath. `dm` instantiates `dm_sba` and maps its `bus_*` ports onto `dbus_if_dm0`.

## Test plan
- Test 1: write `sbcs`=0x00140000 (readonaddr, WORD), then `sbaddress0`=0x3000000C.
  - Expect one READ WORD on the bus at 0x3000000C.
  - `sbdata0` equals the GPIO output value.
  - sbbusy returns to 0 within 4 cycles of `bus_bdone`.
- Test 2: with sbautoincrement=1 and WORD size, set `sbaddress0`=0x10000000, then write `sbdata0` = 0xDEADBEEF, 0x12345678, 0xCAFEF00D.
  - Expect WRITEs at 0x10000000, 0x10000004 and 0x10000008.
  - `sbaddress0` ends at 0x1000000C.
- Test 3: HALFWORD access to 0x10000001 gives sberror=3 and no `bus_bstart`. A subsequent `sbaddress0` write issues nothing until `sbcs` is written with bit 13 and bit 12 set; after that write, sberror=0.
- Test 4: hold `bus_bdone` at 0 with `TIMEOUT_CYCLES`=8. Expect sberror=1 nine cycles after `bus_bstart`, with sbbusy=0.
- Test 5: write `sbdata0` while a read is in WAIT. Expect sbbusyerror=1, `sbdata0` unchanged, and no second `bus_bstart`.
- Test 6: assert `rst_n`=0 mid-WAIT. Expect all outputs at their reset values immediately, and no bus request after `rst_n` is released.
